// File: rtl/fft_but_seq.sv
// Radix-2 DIT butterfly sequencer: walks every stage of an in-place FFT over a
// dual-port sample RAM, feeds the butterfly unit and writes its results back.
module fft_but_seq #(
    parameter int SAMPLE_W   = 32,
    parameter int TWDL_W     = 10,
    parameter int N_LOG2     = 7,
    parameter int PEND_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    ram_rd_en,
    output logic [N_LOG2-1:0]       ram_rd_addr,
    input  logic [2*SAMPLE_W-1:0]   ram_rd_data,
    output logic                    ram_wr_en,
    output logic [N_LOG2-1:0]       ram_wr_addr,
    output logic [2*SAMPLE_W-1:0]   ram_wr_data,
    output logic [N_LOG2-2:0]       twdl_addr,
    input  logic [2*TWDL_W-1:0]     twdl_data,
    output logic [SAMPLE_W-1:0]     sample_a_re,
    output logic [SAMPLE_W-1:0]     sample_a_im,
    output logic [SAMPLE_W-1:0]     sample_b_re,
    output logic [SAMPLE_W-1:0]     sample_b_im,
    output logic [TWDL_W-1:0]       twdl_re,
    output logic [TWDL_W-1:0]       twdl_im,
    output logic                    sample_rdy,
    input  logic [SAMPLE_W-1:0]     res_re,
    input  logic [SAMPLE_W-1:0]     res_im,
    input  logic                    res_rdy,
    output logic                    err_unexp_res
);
    localparam int SW = $clog2(N_LOG2);
    localparam int PW = $clog2(PEND_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [SW-1:0]     S_LAST      = SW'(N_LOG2 - 1);
    localparam logic [N_LOG2-2:0] K_LAST      = '1;
    localparam logic [CW:0]       ISSUE_LIMIT = (CW+1)'(PEND_DEPTH - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [N_LOG2-1:0] pair_top(input logic [N_LOG2-2:0] k, input logic [SW-1:0] s);
        logic [N_LOG2-1:0] kx;
        logic [N_LOG2-1:0] mask;
        kx   = {1'b0, k};
        mask = (N_LOG2'(1'b1) << s) - N_LOG2'(1'b1);
        return (((kx >> s) << s) << 1) + (kx & mask);
    endfunction

    function automatic logic [N_LOG2-2:0] twdl_index(input logic [N_LOG2-2:0] k, input logic [SW-1:0] s);
        logic [N_LOG2-2:0] mask;
        mask = ((N_LOG2-1)'(1'b1) << s) - (N_LOG2-1)'(1'b1);
        return (k & mask) << ((N_LOG2 - 1) - int'(s));
    endfunction

    state_t                  state_q, state_d;
    logic [SW-1:0]           stage_q, stage_d;
    logic [N_LOG2-2:0]       k_q, k_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_a_q, rd_a_d;
    logic                    rd_b_q, rd_b_d;
    logic [2*N_LOG2-1:0]     pair_q, pair_d;
    logic [2*SAMPLE_W-1:0]   a_hold_q, a_hold_d;
    logic [2*TWDL_W-1:0]     w_hold_q, w_hold_d;
    logic [2*SAMPLE_W-1:0]   samp_a_q, samp_a_d;
    logic [2*SAMPLE_W-1:0]   samp_b_q, samp_b_d;
    logic [2*TWDL_W-1:0]     w_q, w_d;
    logic                    sample_rdy_q, sample_rdy_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    beat_q, beat_d;
    logic                    err_q, err_d;
    logic                    wr_en_q, wr_en_d;
    logic [N_LOG2-1:0]       wr_addr_q, wr_addr_d;
    logic [2*SAMPLE_W-1:0]   wr_data_q, wr_data_d;
    logic [2*N_LOG2-1:0]     pend_q [PEND_DEPTH];

    logic [N_LOG2-1:0]       top_s, bot_s;
    logic [N_LOG2-2:0]       tw_s;
    logic [2*N_LOG2-1:0]     head_s;
    logic                    room_s, rd_en_s, push_s, pop_s;

    assign top_s  = pair_top(k_q, stage_q);
    assign bot_s  = top_s + (N_LOG2'(1'b1) << stage_q);
    assign tw_s   = twdl_index(k_q, stage_q);
    assign head_s = pend_q[rd_ptr_q];
    // An issue between RD_B and its queue push still occupies an entry.
    assign room_s = ({1'b0, cnt_q} + {{CW{1'b0}}, rd_b_q}) <= ISSUE_LIMIT;

    // Next-state, read/issue pipeline, pending queue and writeback logic.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        k_d          = k_q;
        rd_a_d       = 1'b0;
        rd_b_d       = 1'b0;
        pair_d       = pair_q;
        a_hold_d     = a_hold_q;
        w_hold_d     = w_hold_q;
        samp_a_d     = samp_a_q;
        samp_b_d     = samp_b_q;
        w_d          = w_q;
        sample_rdy_d = 1'b0;
        beat_d       = beat_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_en_s      = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    stage_d = '0;
                    k_d     = '0;
                    state_d = RD_A;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_A: begin
                if (room_s) begin
                    rd_en_s = 1'b1;
                    rd_a_d  = 1'b1;
                    state_d = RD_B;
                end else begin
                    state_d = RD_A;
                end
            end
            RD_B: begin
                rd_en_s = 1'b1;
                rd_b_d  = 1'b1;
                pair_d  = {top_s, bot_s};
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d     = k_q + (N_LOG2-1)'(1'b1);
                    state_d = RD_A;
                end
            end
            DRAIN: begin
                // Next stage may only read once every result of this one is written.
                if (!rd_b_q && (cnt_q == '0)) begin
                    if (stage_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q + SW'(1'b1);
                        k_d     = '0;
                        state_d = RD_A;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_a_q) begin
            a_hold_d = ram_rd_data;
            w_hold_d = twdl_data;
        end else begin
            a_hold_d = a_hold_q;
        end

        if (rd_b_q) begin
            samp_b_d     = ram_rd_data;
            samp_a_d     = a_hold_q;
            w_d          = w_hold_q;
            sample_rdy_d = 1'b1;
            push_s       = 1'b1;
        end else begin
            sample_rdy_d = 1'b0;
        end

        if (res_rdy) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else if (!beat_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = head_s[2*N_LOG2-1:N_LOG2];
                wr_data_d = {res_re, res_im};
                beat_d    = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = head_s[N_LOG2-1:0];
                wr_data_d = {res_re, res_im};
                beat_d    = 1'b0;
                pop_s     = 1'b1;
            end
        end else begin
            wr_en_d = 1'b0;
        end

        wr_ptr_d = wr_ptr_q + PW'(push_s);
        rd_ptr_d = rd_ptr_q + PW'(pop_s);
        cnt_d    = cnt_q + CW'(push_s) - CW'(pop_s);
        busy_d   = (state_d == RD_A) || (state_d == RD_B) || (state_d == DRAIN);
        done_d   = (state_d == DONE);
    end

    // State, pipeline and writeback registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            k_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_a_q       <= 1'b0;
            rd_b_q       <= 1'b0;
            pair_q       <= '0;
            a_hold_q     <= '0;
            w_hold_q     <= '0;
            samp_a_q     <= '0;
            samp_b_q     <= '0;
            w_q          <= '0;
            sample_rdy_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            beat_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            k_q          <= k_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_a_q       <= rd_a_d;
            rd_b_q       <= rd_b_d;
            pair_q       <= pair_d;
            a_hold_q     <= a_hold_d;
            w_hold_q     <= w_hold_d;
            samp_a_q     <= samp_a_d;
            samp_b_q     <= samp_b_d;
            w_q          <= w_d;
            sample_rdy_q <= sample_rdy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Pending-writeback address storage; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pend_q[wr_ptr_q] <= pair_q;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram_rd_en     = rd_en_s;
    assign ram_rd_addr   = (state_q == RD_B) ? bot_s : top_s;
    assign twdl_addr     = tw_s;
    assign ram_wr_en     = wr_en_q;
    assign ram_wr_addr   = wr_addr_q;
    assign ram_wr_data   = wr_data_q;
    assign sample_a_re   = samp_a_q[2*SAMPLE_W-1:SAMPLE_W];
    assign sample_a_im   = samp_a_q[SAMPLE_W-1:0];
    assign sample_b_re   = samp_b_q[2*SAMPLE_W-1:SAMPLE_W];
    assign sample_b_im   = samp_b_q[SAMPLE_W-1:0];
    assign twdl_re       = w_q[2*TWDL_W-1:TWDL_W];
    assign twdl_im       = w_q[TWDL_W-1:0];
    assign sample_rdy    = sample_rdy_q;
    assign err_unexp_res = err_q;

endmodule

// File: tb/tb_fft_but_seq.sv
// Bench for fft_but_seq at N=8: RAM/ROM models plus a butterfly model with
// configurable latency; directed runs against hand-computed FFT results.
module tb_fft_but_seq;
    localparam int SW = 32;
    localparam int TW = 10;
    localparam int NL = 3;
    localparam int PD = 4;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic ram_rd_en, ram_wr_en, sample_rdy, res_rdy, err_unexp_res;
    logic [NL-1:0] ram_rd_addr, ram_wr_addr;
    logic [2*SW-1:0] ram_rd_data, ram_wr_data;
    logic [NL-2:0] twdl_addr;
    logic [2*TW-1:0] twdl_data;
    logic [SW-1:0] sample_a_re, sample_a_im, sample_b_re, sample_b_im, res_re, res_im;
    logic [TW-1:0] twdl_re, twdl_im;

    always #5 clk = ~clk;

    fft_but_seq #(.SAMPLE_W(SW), .TWDL_W(TW), .N_LOG2(NL), .PEND_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .twdl_addr(twdl_addr), .twdl_data(twdl_data),
        .sample_a_re(sample_a_re), .sample_a_im(sample_a_im),
        .sample_b_re(sample_b_re), .sample_b_im(sample_b_im),
        .twdl_re(twdl_re), .twdl_im(twdl_im), .sample_rdy(sample_rdy),
        .res_re(res_re), .res_im(res_im), .res_rdy(res_rdy),
        .err_unexp_res(err_unexp_res)
    );

    // W^k = exp(-j*2*pi*k/8) at 256 = 1.0
    function automatic logic [2*TW-1:0] rom_w(input logic [NL-2:0] i);
        case (i)
            2'd0:    return {10'h100, 10'h000};
            2'd1:    return {10'h0B5, 10'h34B};
            2'd2:    return {10'h000, 10'h300};
            default: return {10'h34B, 10'h34B};
        endcase
    endfunction

    function automatic logic [63:0] cpx(input int re, input int im);
        return {re[31:0], im[31:0]};
    endfunction

    logic [63:0] mem [N];
    logic        pre_en;
    logic [2:0]  pre_addr;
    logic [63:0] pre_data;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        twdl_data <= rom_w(twdl_addr);
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    typedef struct {
        int unsigned due;
        logic [31:0] re;
        logic [31:0] im;
        bit          last;
    } beat_t;

    beat_t       bq[$];
    logic [2:0]  rd_log[$];
    logic [1:0]  tw_log[$];
    int unsigned acyc[$];
    int unsigned cyc;
    int lat, log_en, epoch, last_epoch, inj_req, inj_seen;
    int wr_cnt, done_cnt, samp_cnt, outst, max_out;
    longint ar, ai, br, bi, wr, wi, pr, pim;
    beat_t b0, b1;
    int n_chk, n_bad;

    // Butterfly model and output monitor, evaluated on the falling edge.
    initial begin
        res_rdy = 1'b0; res_re = '0; res_im = '0;
        cyc = 0; wr_cnt = 0; done_cnt = 0; samp_cnt = 0; outst = 0; max_out = 0;
        last_epoch = 0; inj_seen = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (epoch != last_epoch) begin
                last_epoch = epoch;
                max_out = 0;
            end
            if (rst) begin
                bq.delete();
                outst = 0;
                res_rdy = 1'b0;
            end else begin
                if (ram_wr_en) wr_cnt++;
                if (done) done_cnt++;
                if (log_en != 0 && ram_rd_en) begin
                    rd_log.push_back(ram_rd_addr);
                    if (rd_log.size() % 2 == 1) begin
                        tw_log.push_back(twdl_addr);
                        acyc.push_back(cyc);
                    end
                end
                if (sample_rdy) begin
                    samp_cnt++;
                    ar = longint'($signed(sample_a_re)); ai = longint'($signed(sample_a_im));
                    br = longint'($signed(sample_b_re)); bi = longint'($signed(sample_b_im));
                    wr = longint'($signed(twdl_re));     wi = longint'($signed(twdl_im));
                    pr  = (wr * br - wi * bi) >>> 8;
                    pim = (wr * bi + wi * br) >>> 8;
                    b0.due = cyc + lat;     b0.re = 32'(ar + pr); b0.im = 32'(ai + pim); b0.last = 1'b0;
                    b1.due = cyc + lat + 1; b1.re = 32'(ar - pr); b1.im = 32'(ai - pim); b1.last = 1'b1;
                    bq.push_back(b0);
                    bq.push_back(b1);
                    outst++;
                    if (outst > max_out) max_out = outst;
                end
                res_rdy = 1'b0;
                if (bq.size() > 0 && bq[0].due <= cyc) begin
                    res_rdy = 1'b1;
                    res_re  = bq[0].re;
                    res_im  = bq[0].im;
                    if (bq[0].last) outst--;
                    void'(bq.pop_front());
                end else if (inj_req != inj_seen) begin
                    inj_seen = inj_req;
                    res_rdy = 1'b1;
                    res_re  = 32'h0000_0055;
                    res_im  = 32'h0000_0066;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: all (100,0); mode 1: (100,0) at bit-reversed position of n=1
    task automatic load(input int mode);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_addr = 3'(i);
            pre_data = (mode == 0 || i == 4) ? cpx(100, 0) : 64'd0;
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic run(input string tag, input bit extra_starts);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = extra_starts && (i == 7 || i == 21);
            if (done_cnt != d0) break;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        check(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_ram(input string tag, input int mode);
        int dre[N] = '{100, 70, 0, -71, -100, -70, 0, 71};
        int dim[N] = '{0, -71, -100, -71, 0, 71, 100, 71};
        for (int i = 0; i < N; i++) begin
            if (mode == 0) check($sformatf("%s_ram%0d", tag, i), mem[i], (i == 0) ? cpx(800, 0) : 64'd0);
            else check($sformatf("%s_ram%0d", tag, i), mem[i], cpx(dre[i], dim[i]));
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [11:0] exp_pair [12] = '{12'h010, 12'h230, 12'h450, 12'h670,
                                   12'h020, 12'h132, 12'h460, 12'h572,
                                   12'h040, 12'h151, 12'h262, 12'h373};

    initial begin
        int w0, s0;
        bit stall;
        n_chk = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        lat = 5; log_en = 0; epoch = 0; inj_req = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_en", 64'(ram_wr_en), 64'd0);
        check("rst_rd_en", 64'(ram_rd_en), 64'd0);
        check("rst_sample_rdy", 64'(sample_rdy), 64'd0);
        check("rst_err", 64'(err_unexp_res), 64'd0);
        rst = 1'b0;

        // all-100 input, latency 5, extra start pulses while busy, address log
        load(0);
        w0 = wr_cnt;
        log_en = 1;
        run("runA_one_done", 1'b1);
        log_en = 0;
        check_ram("runA", 0);
        check("runA_err", 64'(err_unexp_res), 64'd0);
        check("runA_writes", 64'(wr_cnt - w0), 64'd24);
        check("runA_reads", 64'(rd_log.size()), 64'd24);
        for (int p = 0; p < 12; p++)
            check($sformatf("pair%0d", p), {52'd0, 1'b0, rd_log[2*p], 1'b0, rd_log[2*p+1], 2'b00, tw_log[p]}, {52'd0, exp_pair[p]});

        // single tone input exercises non-trivial twiddles
        load(1);
        run("runB_one_done", 1'b0);
        check_ram("runB", 1);

        // latency 20 forces issue throttling
        lat = 20;
        epoch++;
        load(0);
        log_en = 1;
        run("runC_one_done", 1'b0);
        log_en = 0;
        check_ram("runC", 0);
        check("runC_err", 64'(err_unexp_res), 64'd0);
        check("runC_no_overflow", 64'(max_out <= PD), 64'd1);
        stall = 1'b0;
        for (int p = 12; p < 23; p++)
            if (p % 4 != 3 && acyc.size() > p + 1 && acyc[p+1] - acyc[p] > 2) stall = 1'b1;
        check("runC_stall", 64'(stall), 64'd1);

        // reset during stage 1, then a clean rerun
        lat = 5;
        load(1);
        s0 = samp_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && samp_cnt - s0 < 6; i++) @(negedge clk);
        check("midrst_reached_stage1", 64'(samp_cnt - s0 >= 6), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_wr_en", 64'(ram_wr_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        w0 = wr_cnt;
        repeat (30) @(negedge clk);
        check("midrst_no_writes", 64'(wr_cnt - w0), 64'd0);
        load(1);
        run("runD_one_done", 1'b0);
        check_ram("runD", 1);

        // unexpected result beat while idle
        w0 = wr_cnt;
        inj_req++;
        repeat (3) @(negedge clk);
        check("inj_no_write", 64'(wr_cnt - w0), 64'd0);
        check("inj_err_set", 64'(err_unexp_res), 64'd1);
        repeat (20) @(negedge clk);
        check("inj_err_sticky", 64'(err_unexp_res), 64'd1);
        pulse_rst();
        check("inj_err_cleared", 64'(err_unexp_res), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
